// File: rtl/ipsxe_floating_point_unpack_double_v1_0.sv
// Unpacks an IEEE-754 operand into the wide {sign, exp, man} sum word used by the FMA round stage.
// Define IPSXE_FLT_UNPACK_SUBNORM_EN to keep subnormals exact; by default they are flushed to zero.
module ipsxe_floating_point_unpack_double_v1_0 #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int W_USER    = 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_aclken,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]           i_float,
  input  logic [W_USER-1:0]                      i_user,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [2*(MAN_WIDTH+1)+EXP_WIDTH+2:0]   o_add_out,
  output logic [3:0]                             o_class,
  output logic [W_USER-1:0]                      o_user
);

  localparam int FW = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int MW = 2 * (MAN_WIDTH + 1) + 1;
  localparam int WW = MW + EXP_WIDTH + 1 + 1;
  localparam int HB = 2 * MAN_WIDTH;
  localparam logic [EXP_WIDTH:0] BIAS = {2'b00, {(EXP_WIDTH-1){1'b1}}};

  // Class vector is {is_nan, is_inf, is_zero, is_subnorm}; all-zero means normal.
  function automatic logic [3:0] classify(input logic [EXP_WIDTH-1:0] e,
                                          input logic [MAN_WIDTH-1:0] f);
    logic e_zero;
    logic e_ones;
    logic f_zero;
    e_zero = (e == {EXP_WIDTH{1'b0}});
    e_ones = (e == {EXP_WIDTH{1'b1}});
    f_zero = (f == {MAN_WIDTH{1'b0}});
    classify = {e_ones & ~f_zero, e_ones & f_zero, e_zero & f_zero, e_zero & ~f_zero};
  endfunction

  logic                   r_s1_valid;
  logic [FW-1:0]          r_s1_float;
  logic [W_USER-1:0]      r_s1_user;
  logic                   r_s2_valid;
  logic [WW-1:0]          r_add_out;
  logic [3:0]             r_class;
  logic [W_USER-1:0]      r_user;

  logic                   w_s1_adv;
  logic                   w_s2_adv;
  logic                   w_sign;
  logic [EXP_WIDTH-1:0]   w_e;
  logic [MAN_WIDTH-1:0]   w_f;
  logic [3:0]             w_cls;
  logic [EXP_WIDTH:0]     w_exp;
  logic [MW-1:0]          w_man;

  assign w_s2_adv = ~r_s2_valid | i_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign o_ready  = w_s1_adv;

  // Stage-2 word build from the registered operand; bits above HB stay zero as add-stage headroom.
  always_comb begin
    w_exp  = {(EXP_WIDTH+1){1'b0}};
    w_man  = {MW{1'b0}};
    w_sign = r_s1_float[FW-1];
    w_e    = r_s1_float[FW-2 -: EXP_WIDTH];
    w_f    = r_s1_float[MAN_WIDTH-1:0];
    w_cls  = classify(w_e, w_f);
    case (w_cls)
      4'b1000: begin
        w_exp                        = {1'b0, w_e} + BIAS;
        w_man[HB]                    = 1'b1;
        w_man[HB-1 -: MAN_WIDTH]     = w_f | {1'b1, {(MAN_WIDTH-1){1'b0}}};
      end
      4'b0100: begin
        w_exp     = {1'b0, w_e} + BIAS;
        w_man[HB] = 1'b1;
      end
      4'b0010: begin
        w_exp = {(EXP_WIDTH+1){1'b0}};
        w_man = {MW{1'b0}};
      end
      4'b0001: begin
`ifdef IPSXE_FLT_UNPACK_SUBNORM_EN
        // Hidden bit left clear; the round stage renormalises by leading-zero count.
        w_exp                    = BIAS + {{EXP_WIDTH{1'b0}}, 1'b1};
        w_man[HB-1 -: MAN_WIDTH] = w_f;
`else
        w_exp = {(EXP_WIDTH+1){1'b0}};
        w_man = {MW{1'b0}};
`endif
      end
      default: begin
        w_exp                    = {1'b0, w_e} + BIAS;
        w_man[HB]                = 1'b1;
        w_man[HB-1 -: MAN_WIDTH] = w_f;
      end
    endcase
  end

  // Stage 1: capture operand and sideband whenever the stage can advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_float <= {FW{1'b0}};
      r_s1_user  <= {W_USER{1'b0}};
    end else if (i_aclken && w_s1_adv) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_float <= i_float;
        r_s1_user  <= i_user;
      end
    end
  end

  // Stage 2: output register; data only changes when a new valid word moves in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_valid <= 1'b0;
      r_add_out  <= {WW{1'b0}};
      r_class    <= 4'b0000;
      r_user     <= {W_USER{1'b0}};
    end else if (i_aclken && w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_add_out <= {w_sign, w_exp, w_man};
        r_class   <= w_cls;
        r_user    <= r_s1_user;
      end
    end
  end

  assign o_valid   = r_s2_valid;
  assign o_add_out = r_add_out;
  assign o_class   = r_class;
  assign o_user    = r_user;

endmodule
